multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_pkg.sv | 15 +
 rtl/multicycle_alu_adder.sv | 12 +
 rtl/multicycle_alu.sv | 104 ++++++++++
 3 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared op encodings and FSM state type for the multicycle ALU.
package multicycle_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_EQ  = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_LTU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multicycle_alu_adder.sv
// Plain nbits-wide modular adder used for the multiply accumulator.
module multicycle_alu_adder #(
  parameter int nbits = 32
) (
  input  logic [nbits-1:0] a,
  input  logic [nbits-1:0] b,
  output logic [nbits-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/eq/ltu, shift-add multiply over nbits cycles.
// Define MULTICYCLE_ALU_EARLY_EXIT_EN to end multiply once the remaining multiplier is zero.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [1:0]       op,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] out
);

  localparam int CW = $clog2(nbits);

  state_t           state, state_nx;
  logic [nbits-1:0] a_q, b_q, acc, out_q;
  logic [nbits-1:0] addend, acc_sum, b_shr;
  logic [CW-1:0]    count;
  logic             last_iter, calc_exit;

  assign istream_rdy = (state == IDLE);
  assign ostream_val = (state == DONE);
  assign out         = out_q;

  assign addend    = b_q[0] ? a_q : '0;
  assign b_shr     = b_q >> 1;
  assign last_iter = (count == CW'(nbits - 1));

  multicycle_alu_adder #(.nbits(nbits)) u_acc_add (
    .a   (acc),
    .b   (addend),
    .sum (acc_sum)
  );

`ifdef MULTICYCLE_ALU_EARLY_EXIT_EN
  assign calc_exit = last_iter || (b_shr == '0);
`else
  assign calc_exit = last_iter;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (istream_val) begin
        if (op == OP_MUL) begin
`ifdef MULTICYCLE_ALU_EARLY_EXIT_EN
          state_nx = (in1 == '0) ? DONE : CALC;
`else
          state_nx = CALC;
`endif
        end else begin
          state_nx = DONE;
        end
      end
      CALC: if (calc_exit) state_nx = DONE;
      DONE: if (ostream_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      count <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (istream_val) begin
          a_q   <= in0;
          b_q   <= in1;
          acc   <= '0;
          count <= '0;
          // Non-multiply results are formed on the accept edge, giving latency 1.
          case (op)
            OP_ADD:  out_q <= in0 + in1;
            OP_EQ:   out_q <= nbits'(in0 == in1);
            OP_LTU:  out_q <= nbits'(in0 < in1);
            default: out_q <= '0;
          endcase
        end
        CALC: begin
          acc   <= acc_sum;
          a_q   <= a_q << 1;
          b_q   <= b_shr;
          count <= count + CW'(1);
          if (calc_exit) out_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
